// File: rtl/mem_port_arbiter.sv
// Multi-client arbiter feeding one line-wide memory port.
// One transaction is outstanding at a time. The winner's request is registered onto the
// memory bus and held until mem_ready or a timeout, then a one-cycle done pulse is returned.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          done,
  output logic [NUM_PORTS-1:0]          stall,
  output logic [LINE_W-1:0]             resp_rdata,
  output logic                          resp_err,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic [LINE_W-1:0]             mem_rdata,
  input  logic                          mem_ready
);

  localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0]    LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q;
  logic [PW-1:0]          win_q;
  logic [PW-1:0]          win_idx;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_PORTS-1:0]   done_q;
  logic                   err_q;
  logic                   mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [LINE_W-1:0]      mem_wdata_q;
  logic [LINE_W-1:0]      rdata_q;
  logic                   any_req;
  logic                   timeout_hit;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [LINE_W-1:0] wdata_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*LINE_W +: LINE_W];
  end

  assign any_req     = |req_valid;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  // Winner select: scan from rr_ptr (round-robin) or from port 0 (fixed priority).
  always_comb begin
    logic        found;
    int unsigned cand;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = (FIXED_PRIO != 0) ? i : ((32'(rr_ptr_q) + i) % NUM_PORTS);
      if (!found && req_valid[PW'(cand)]) begin
        win_idx = PW'(cand);
        found   = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StBusy;
      StBusy:  if (mem_ready || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath: grant capture, memory bus hold, completion and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            win_q       <= win_idx;
            mem_addr_q  <= addr_arr[win_idx];
            mem_wdata_q <= wdata_arr[win_idx];
            mem_read_q  <= ~req_write[win_idx];
            mem_write_q <= req_write[win_idx];
            cnt_q       <= '0;
          end
        end
        StBusy: begin
          if (mem_ready) begin
            // mem_ready beats a simultaneous timeout.
            if (mem_read_q) rdata_q <= mem_rdata;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= NUM_PORTS'(1) << win_q;
            err_q       <= 1'b0;
          end else if (timeout_hit) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= NUM_PORTS'(1) << win_q;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q <= '0;
          err_q  <= 1'b0;
          if (FIXED_PRIO == 0) rr_ptr_q <= (win_q == LAST_PORT) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done       = done_q;
  assign stall      = req_valid & ~done_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: 2-port round-robin with timeout, 4-port round-robin, 2-port fixed priority.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 2-port, default widths, TIMEOUT = 8
  logic [1:0]   a_valid = '0, a_write = '0;
  logic [63:0]  a_addr = '0;
  logic [255:0] a_wdata = '0;
  logic [1:0]   a_done, a_stall;
  logic [127:0] a_rdata, a_mwdata, a_mrdata = '0;
  logic         a_err, a_mrd, a_mwr, a_mready = 1'b0;
  logic [31:0]  a_maddr;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .LINE_W(128), .FIXED_PRIO(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr),
    .req_wdata(a_wdata), .done(a_done), .stall(a_stall), .resp_rdata(a_rdata),
    .resp_err(a_err), .mem_read(a_mrd), .mem_write(a_mwr), .mem_addr(a_maddr),
    .mem_wdata(a_mwdata), .mem_rdata(a_mrdata), .mem_ready(a_mready)
  );

  // 4-port round-robin, no timeout
  logic [3:0]   b_valid = '0, b_write = '0;
  logic [63:0]  b_addr = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
  logic [127:0] b_wdata = '0;
  logic [3:0]   b_done, b_stall;
  logic [31:0]  b_rdata, b_mwdata, b_mrdata = 32'hCAFE_0001;
  logic         b_err, b_mrd, b_mwr, b_mready = 1'b0;
  logic [15:0]  b_maddr;

  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .LINE_W(32), .FIXED_PRIO(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr),
    .req_wdata(b_wdata), .done(b_done), .stall(b_stall), .resp_rdata(b_rdata),
    .resp_err(b_err), .mem_read(b_mrd), .mem_write(b_mwr), .mem_addr(b_maddr),
    .mem_wdata(b_mwdata), .mem_rdata(b_mrdata), .mem_ready(b_mready)
  );

  // 2-port fixed priority
  logic [1:0]   f_valid = '0, f_write = '0;
  logic [31:0]  f_addr = {16'h0B00, 16'h0A00};
  logic [63:0]  f_wdata = '0;
  logic [1:0]   f_done, f_stall;
  logic [31:0]  f_rdata, f_mwdata, f_mrdata = 32'h0;
  logic         f_err, f_mrd, f_mwr, f_mready = 1'b0;
  logic [15:0]  f_maddr;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .LINE_W(32), .FIXED_PRIO(1), .TIMEOUT(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(f_valid), .req_write(f_write), .req_addr(f_addr),
    .req_wdata(f_wdata), .done(f_done), .stall(f_stall), .resp_rdata(f_rdata),
    .resp_err(f_err), .mem_read(f_mrd), .mem_write(f_mwr), .mem_addr(f_maddr),
    .mem_wdata(f_mwdata), .mem_rdata(f_mrdata), .mem_ready(f_mready)
  );

  localparam logic [127:0] LINE_A = {32{4'hA}};
  localparam logic [127:0] LINE_W1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] LINE_C = 128'h3C3C_3C3C_0000_1111_2222_3333_4444_5555;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;

    // Reset state
    #2;
    chk("rst_done", {126'b0, a_done}, 128'h0);
    chk("rst_mrd", {127'b0, a_mrd}, 128'h0);
    chk("rst_maddr", {96'b0, a_maddr}, 128'h0);
    chk("rst_rdata", a_rdata, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single read, port 0, mem_ready three cycles after mem_read rises
    a_valid = 2'b01; a_write = 2'b00; a_addr[31:0] = 32'h0000_0040;
    hi = 0;
    tick(); hi += int'(a_mrd);
    chk("rd_addr", {96'b0, a_maddr}, 128'h40);
    chk("rd_stall", {126'b0, a_stall}, 128'h1);
    tick(); hi += int'(a_mrd);
    tick(); hi += int'(a_mrd);
    tick(); hi += int'(a_mrd);
    chk("rd_no_done_early", {126'b0, a_done}, 128'h0);
    a_mready = 1'b1; a_mrdata = LINE_A;
    tick(); hi += int'(a_mrd);
    a_mready = 1'b0;
    chk("rd_done", {126'b0, a_done}, 128'h1);
    chk("rd_rdata", a_rdata, LINE_A);
    chk("rd_err", {127'b0, a_err}, 128'h0);
    chk("rd_stall_at_done", {126'b0, a_stall}, 128'h0);
    chk("rd_mrd_cycles", 128'(hi), 128'd4);
    a_valid = 2'b00;
    tick();
    chk("rd_done_one_cycle", {126'b0, a_done}, 128'h0);

    // Write, port 1; resp_rdata must not change
    a_valid = 2'b10; a_write = 2'b10; a_addr[63:32] = 32'h0000_1000; a_wdata[255:128] = LINE_W1;
    tick();
    chk("wr_mwr", {127'b0, a_mwr}, 128'h1);
    chk("wr_mrd", {127'b0, a_mrd}, 128'h0);
    chk("wr_addr", {96'b0, a_maddr}, 128'h1000);
    chk("wr_wdata", a_mwdata, LINE_W1);
    a_mready = 1'b1; a_mrdata = 128'h5555;
    tick();
    a_mready = 1'b0;
    chk("wr_done", {126'b0, a_done}, 128'h2);
    chk("wr_rdata_kept", a_rdata, LINE_A);
    chk("wr_mwr_clear", {127'b0, a_mwr}, 128'h0);
    a_valid = 2'b00; a_write = 2'b00;
    tick();

    // Timeout: port 0 read, mem_ready held low (rr_ptr = 0 after port 1)
    a_valid = 2'b01;
    tick();
    chk("to_busy_mrd", {127'b0, a_mrd}, 128'h1);
    hi = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      hi += int'(a_done != 2'b00);
    end
    chk("to_no_early_done", 128'(hi), 128'd0);
    tick();
    chk("to_done", {126'b0, a_done}, 128'h1);
    chk("to_err", {127'b0, a_err}, 128'h1);
    chk("to_mrd_low", {127'b0, a_mrd}, 128'h0);
    chk("to_rdata_kept", a_rdata, LINE_A);
    a_valid = 2'b00;
    tick();
    chk("to_err_clear", {127'b0, a_err}, 128'h0);

    // Next request served normally
    a_valid = 2'b01;
    tick();
    a_mready = 1'b1; a_mrdata = LINE_C;
    tick();
    a_mready = 1'b0;
    chk("post_to_done", {126'b0, a_done}, 128'h1);
    chk("post_to_err", {127'b0, a_err}, 128'h0);
    chk("post_to_rdata", a_rdata, LINE_C);
    a_valid = 2'b00;
    tick();

    // Async reset while BUSY (rr_ptr = 1, so port 1 wins first)
    a_valid = 2'b11;
    tick();
    chk("rst_busy_addr", {96'b0, a_maddr}, 128'h1000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mrd", {127'b0, a_mrd}, 128'h0);
    chk("arst_maddr", {96'b0, a_maddr}, 128'h0);
    chk("arst_rdata", a_rdata, 128'h0);
    hi = 0;
    tick(); hi += int'(a_done != 2'b00);
    tick(); hi += int'(a_done != 2'b00);
    chk("arst_no_done", 128'(hi), 128'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_port0_first", {96'b0, a_maddr}, 128'h40);
    a_mready = 1'b1;
    tick();
    a_mready = 1'b0;
    chk("arst_done0", {126'b0, a_done}, 128'h1);
    a_valid = 2'b00;

    // Round-robin, 4 ports, mem_ready held high
    b_valid = 4'hF; b_mready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("rr_addr%0d", g), {112'b0, b_maddr}, 128'(16'h0100 * (g % 4 + 1)));
      tick();
      chk($sformatf("rr_done%0d", g), {124'b0, b_done}, 128'(4'b0001 << (g % 4)));
      chk($sformatf("rr_stall%0d", g), {124'b0, b_stall}, 128'(4'hF & ~(4'b0001 << (g % 4))));
      tick();
    end
    b_valid = 4'h0; b_mready = 1'b0;

    // Fixed priority: port 0 re-requests and wins twice before port 1
    f_valid = 2'b11; f_mready = 1'b1;
    tick();
    chk("fp_addr0a", {112'b0, f_maddr}, 128'h0A00);
    tick();
    chk("fp_done0a", {126'b0, f_done}, 128'h1);
    chk("fp_stall1", {126'b0, f_stall}, 128'h2);
    tick();
    tick();
    chk("fp_addr0b", {112'b0, f_maddr}, 128'h0A00);
    tick();
    chk("fp_done0b", {126'b0, f_done}, 128'h1);
    f_valid = 2'b10;
    tick();
    tick();
    chk("fp_addr1", {112'b0, f_maddr}, 128'h0B00);
    tick();
    chk("fp_done1", {126'b0, f_done}, 128'h2);
    f_valid = 2'b00; f_mready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- N-client arbiter between per-client cache controllers (port 0 = data cache, port 1 = instruction cache, further ports reserved) and a single line-wide main-memory port.
- Registers the winning client's read/write request and holds it on the memory bus until memory signals completion.
- Returns read data and a one-cycle done pulse to the winning client.
- Adds to the single-outstanding memory-arbitration scheme: parametrised port count and widths, selectable round-robin or fixed priority, per-client stall outputs, and a completion timeout.

Parameters:
- NUM_PORTS, 2, number of clients, 2..8.
- ADDR_W, 32, address width.
- LINE_W, 128, cache line width.
- FIXED_PRIO, 0. 0 = round-robin; 1 = fixed priority, lowest index wins.
- TIMEOUT, 0, max cycles in BUSY before forced error completion. 0 = disabled.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-client request; held until that client's done.
- req_write  in  NUM_PORTS  1 = line write, 0 = line read.
- req_addr  in  NUM_PORTS*ADDR_W  client i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  client i at [i*LINE_W +: LINE_W].
- done  out  NUM_PORTS  one-cycle completion pulse, one-hot or zero.
- stall  out  NUM_PORTS  req_valid[i] & ~done[i]; combinational.
- resp_rdata  out  LINE_W  read line; valid while done is high, held afterwards.
- resp_err  out  1  high with done when the completion was a timeout.
- mem_read  out  1  memory read request, registered.
- mem_write  out  1  memory write request, registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  LINE_W  registered.
- mem_rdata  in  LINE_W  sampled when mem_ready is high in BUSY.
- mem_ready  in  1  completion strobe; ignored outside BUSY.

Behaviour:
- Reset (async, any state): state IDLE, rr_ptr = 0, timeout counter 0.
- Reset values of outputs: done, resp_err, mem_read, mem_write = 0; mem_addr, mem_wdata, resp_rdata = 0. Any in-flight transaction is abandoned with no done.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any req_valid is high, pick winner w.
    - FIXED_PRIO = 1: lowest set index.
    - FIXED_PRIO = 0: first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - At the edge, latch w, mem_addr, mem_wdata, mem_read = ~req_write[w], mem_write = req_write[w]; go to BUSY.
  - The request is therefore visible on the memory bus one cycle after req_valid is first sampled.
- BUSY:
  - Memory outputs are held stable.
  - On a cycle with mem_ready = 1:
    - Latch mem_rdata into resp_rdata (reads only; writes leave resp_rdata unchanged).
    - Clear mem_read/mem_write.
    - Go to DONE with done[w] = 1, resp_err = 0.
  - Timeout: if TIMEOUT > 0 and the counter reaches TIMEOUT-1 with mem_ready still 0:
    - Clear mem_read/mem_write; go to DONE with done[w] = 1, resp_err = 1.
    - resp_rdata is unchanged.
  - The counter clears on entry to BUSY.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - If FIXED_PRIO = 0, rr_ptr = (w+1) mod NUM_PORTS.
  - Requests are not sampled in DONE, so a client that drops req_valid after its done is never re-granted.
- Minimum turnaround: requests sampled in IDLE at cycle t give mem_read high at t+1. With mem_ready at t+1+k (k >= 0), done is high at t+2+k. The next grant is sampled at t+3+k.
- Only one memory transaction is outstanding; losers see stall = 1 throughout.
- A req_valid dropped mid-transaction does not cancel it; done still pulses.
- mem_ready high in IDLE or DONE is ignored.
- mem_ready on the same cycle the timeout fires: mem_ready wins, resp_err = 0.
- Illegal requests are not checked; NUM_PORTS = 1 degenerates to a pass-through registered path.

Test Plan:
- Single read, port 0, addr 0x0000_0040, mem_ready 3 cycles after mem_read rises, mem_rdata = 0xAAAA...A -> done = 2'b01 for one cycle, resp_rdata = 0xAAAA...A, mem_read high exactly 4 cycles.
- Write, port 1, addr 0x0000_1000, wdata 0x1234...: check mem_write = 1, mem_read = 0, mem_addr/mem_wdata match; after mem_ready, expect done = 2'b10 and resp_rdata unchanged.
- Round-robin, NUM_PORTS = 4, ports 0 to 3 requesting continuously, mem_ready immediate -> grant order 0, 1, 2, 3, 0; each done spaced 3 cycles; stall high on waiting ports.
- Fixed priority, FIXED_PRIO = 1, ports 0 and 1 both requesting, port 0 re-requesting immediately -> port 0 granted twice before port 1.
- Timeout, TIMEOUT = 8, mem_ready held 0 -> done[w] and resp_err = 1 exactly 8 cycles after BUSY entry; mem_read low afterwards; next request is served normally.
- rst_n low 2 cycles while in BUSY -> all outputs 0 immediately (async), no done pulse; after release, rr_ptr = 0 and port 0 wins first.
